// File: rtl/conv_kernel_engine.sv
// KxK convolution engine: signed programmable kernel, rounding right shift and clamp,
// 3-stage valid/ready pipeline with a drain-then-swap shadow kernel bank.
module conv_kernel_engine #(
    parameter int PIX_BITS   = 8,
    parameter int K          = 3,
    parameter int COEF_BITS  = 8,
    parameter int SHIFT_BITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PIX_BITS*K*K-1:0]    pix_in_data,
    input  logic                       pix_in_valid,
    output logic                       pix_in_ready,
    output logic [PIX_BITS-1:0]        pix_out_data,
    output logic                       pix_out_valid,
    input  logic                       pix_out_ready,
    input  logic                       coef_wr_en,
    input  logic [COEF_BITS-1:0]       coef_wr_data,
    input  logic [SHIFT_BITS-1:0]      cfg_shift,
    input  logic                       cfg_commit,
    output logic                       cfg_busy,
    output logic                       cfg_err,
    output logic                       cfg_state_dbg_o
);

    localparam int NM     = K * K;
    localparam int PROD_W = PIX_BITS + COEF_BITS + 1;
    localparam int ACC_W  = PROD_W + $clog2(NM);
    localparam int WPTR_W = $clog2(NM + 1);
    localparam logic [WPTR_W-1:0] WPTR_FULL = WPTR_W'(NM);
    localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W+1)'((1 << PIX_BITS) - 1);

    // Handshake: a beat moves on either side only when valid && ready in the same cycle;
    // valid must not depend on ready, and a stalled output holds data and valid.
    typedef enum logic [0:0] {CFG_IDLE, CFG_DRAIN} cfg_state_e;

    cfg_state_e cfg_state_q, cfg_state_d;

    logic signed [COEF_BITS-1:0]  act_coef_q [NM];
    logic signed [COEF_BITS-1:0]  act_coef_d [NM];
    logic signed [COEF_BITS-1:0]  shadow_q   [NM];
    logic signed [COEF_BITS-1:0]  shadow_d   [NM];
    logic signed [COEF_BITS-1:0]  snap_q     [NM];
    logic signed [COEF_BITS-1:0]  snap_d     [NM];
    logic [SHIFT_BITS-1:0]        shift_q, shift_d;
    logic [SHIFT_BITS-1:0]        snap_shift_q, snap_shift_d;
    logic [WPTR_W-1:0]            wptr_q, wptr_d, wptr_w;
    logic                         cfg_err_q, cfg_err_d;

    logic                         s1_valid_q, s2_valid_q, out_valid_q;
    logic signed [PROD_W-1:0]     prod_q [NM];
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [PIX_BITS-1:0]          out_data_q, sat_d;
    logic signed [ACC_W:0]        acc_ext, rnd, shr;
    logic [ACC_W:0]               bias;

    logic stall, in_fire, drained;

    function automatic logic signed [COEF_BITS-1:0] dflt_coef(input int i);
        int r;
        int c;
        r = i / K;
        c = i % K;
        if (K == 3) begin
            return COEF_BITS'((r == 1 ? 2 : 1) * (c == 1 ? 2 : 1));
        end
        return (i == NM / 2) ? COEF_BITS'(1) : '0;
    endfunction

    function automatic logic signed [PROD_W-1:0] tap_mul(input logic [PIX_BITS-1:0] p,
                                                         input logic signed [COEF_BITS-1:0] c);
        logic signed [PROD_W-1:0] pe;
        logic signed [PROD_W-1:0] ce;
        pe = $signed(PROD_W'(p));
        ce = PROD_W'(c);
        return pe * ce;
    endfunction

    assign stall           = out_valid_q && !pix_out_ready;
    assign cfg_busy        = (cfg_state_q == CFG_DRAIN);
    assign pix_in_ready    = !stall && !cfg_busy;
    assign in_fire         = pix_in_valid && pix_in_ready;
    assign drained         = !s1_valid_q && !s2_valid_q && !out_valid_q;
    assign pix_out_valid   = out_valid_q;
    assign pix_out_data    = out_data_q;
    assign cfg_err         = cfg_err_q;
    assign cfg_state_dbg_o = cfg_state_q;

    always_comb begin
        acc_d = '0;
        for (int i = 0; i < NM; i++) begin
            acc_d = acc_d + ACC_W'(prod_q[i]);
        end
    end

    // Round half up before the arithmetic shift, then clamp to the pixel range.
    always_comb begin
        acc_ext = (ACC_W+1)'(acc_q);
        bias    = '0;
        if (shift_q != '0) begin
            bias = (ACC_W+1)'(1) << (shift_q - SHIFT_BITS'(1));
        end
        rnd = acc_ext + $signed(bias);
        shr = rnd >>> shift_q;
        if (shr[ACC_W]) begin
            sat_d = '0;
        end else if (shr > PIX_MAX) begin
            sat_d = '1;
        end else begin
            sat_d = shr[PIX_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
            for (int i = 0; i < NM; i++) begin
                prod_q[i] <= '0;
            end
        end else if (!stall) begin
            s1_valid_q  <= in_fire;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (in_fire) begin
                for (int i = 0; i < NM; i++) begin
                    prod_q[i] <= tap_mul(pix_in_data[i*PIX_BITS +: PIX_BITS], act_coef_q[i]);
                end
            end
            if (s1_valid_q) begin
                acc_q <= acc_d;
            end
            if (s2_valid_q) begin
                out_data_q <= sat_d;
            end
        end
    end

    // The write is applied before the commit looks at the pointer, so a commit in the
    // same cycle as the ninth write succeeds and snapshots that write too.
    always_comb begin
        cfg_state_d  = cfg_state_q;
        shadow_d     = shadow_q;
        snap_d       = snap_q;
        act_coef_d   = act_coef_q;
        shift_d      = shift_q;
        snap_shift_d = snap_shift_q;
        cfg_err_d    = 1'b0;
        wptr_w       = wptr_q;

        if (coef_wr_en) begin
            if (wptr_q < WPTR_FULL) begin
                shadow_d[wptr_q] = coef_wr_data;
                wptr_w           = wptr_q + WPTR_W'(1);
            end else begin
                cfg_err_d = 1'b1;
            end
        end
        wptr_d = wptr_w;

        case (cfg_state_q)
            CFG_IDLE: begin
                if (cfg_commit) begin
                    wptr_d = '0;
                    if (wptr_w == WPTR_FULL) begin
                        snap_d       = shadow_d;
                        snap_shift_d = cfg_shift;
                        cfg_state_d  = CFG_DRAIN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            CFG_DRAIN: begin
                if (cfg_commit) begin
                    cfg_err_d = 1'b1;
                end
                if (drained) begin
                    act_coef_d  = snap_q;
                    shift_d     = snap_shift_q;
                    cfg_state_d = CFG_IDLE;
                end
            end
            default: cfg_state_d = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_state_q  <= CFG_IDLE;
            shift_q      <= (K == 3) ? SHIFT_BITS'(4) : '0;
            snap_shift_q <= '0;
            wptr_q       <= '0;
            cfg_err_q    <= 1'b0;
            for (int i = 0; i < NM; i++) begin
                act_coef_q[i] <= dflt_coef(i);
                shadow_q[i]   <= '0;
                snap_q[i]     <= '0;
            end
        end else begin
            cfg_state_q  <= cfg_state_d;
            shift_q      <= shift_d;
            snap_shift_q <= snap_shift_d;
            wptr_q       <= wptr_d;
            cfg_err_q    <= cfg_err_d;
            act_coef_q   <= act_coef_d;
            shadow_q     <= shadow_d;
            snap_q       <= snap_d;
        end
    end

endmodule
